// File: rtl/alu_serial_unit.sv
// Bit-serial ADD/AND/OR unit: receives op_code, op_1 and op_2 LSB first, then streams the result back LSB first.
// Optional macro ALU_SERIAL_CARRY_OUT_EN appends the ADD carry-out as one extra result bit.
module alu_serial_unit #(
  parameter int REGISTER_SIZE = 32,
  parameter int OP_WIDTH      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_valid,
  input  logic rx_bit,
  output logic rx_ready,
  output logic tx_valid,
  output logic tx_bit,
  input  logic tx_ready,
  output logic busy,
  output logic err
);

`ifdef ALU_SERIAL_CARRY_OUT_EN
  localparam int RES_W = REGISTER_SIZE + 1;
`else
  localparam int RES_W = REGISTER_SIZE;
`endif
  localparam int CNT_W = $clog2(RES_W + 1);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(2);

  typedef enum logic [2:0] {
    S_RECV_OP,
    S_RECV_OP1,
    S_RECV_OP2,
    S_EXEC,
    S_SEND
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [OP_WIDTH-1:0]      r_op;
  logic [REGISTER_SIZE-1:0] r_op1, r_op2;
  logic [RES_W-1:0]         r_result, w_result_nxt;
  logic [REGISTER_SIZE:0]   w_sum;
  logic [RES_W-1:0]         w_exec_val;
  logic                     w_unsupported;
  logic                     w_rx_fire, w_tx_fire;

  assign w_rx_fire = rx_valid && rx_ready;
  assign w_tx_fire = tx_valid && tx_ready;
  assign w_sum     = {1'b0, r_op1} + {1'b0, r_op2};

  always_comb begin
    w_exec_val    = '0;
    w_unsupported = 1'b0;
    case (r_op)
`ifdef ALU_SERIAL_CARRY_OUT_EN
      OP_ADD:  w_exec_val = w_sum;
`else
      OP_ADD:  w_exec_val = w_sum[REGISTER_SIZE-1:0];
`endif
      OP_AND:  w_exec_val = RES_W'(r_op1 & r_op2);
      OP_OR:   w_exec_val = RES_W'(r_op1 | r_op2);
      default: w_unsupported = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    rx_ready     = 1'b0;
    tx_valid     = 1'b0;
    tx_bit       = 1'b0;
    err          = 1'b0;
    busy         = !((r_state == S_RECV_OP) && (r_cnt == '0));
    case (r_state)
      S_RECV_OP: begin
        rx_ready = 1'b1;
        if (w_rx_fire) begin
          if (r_cnt == CNT_W'(OP_WIDTH - 1)) begin
            w_state_nxt = S_RECV_OP1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_RECV_OP1: begin
        rx_ready = 1'b1;
        if (w_rx_fire) begin
          if (r_cnt == CNT_W'(REGISTER_SIZE - 1)) begin
            w_state_nxt = S_RECV_OP2;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_RECV_OP2: begin
        rx_ready = 1'b1;
        if (w_rx_fire) begin
          if (r_cnt == CNT_W'(REGISTER_SIZE - 1)) begin
            w_state_nxt = S_EXEC;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_EXEC: begin
        w_result_nxt = w_exec_val;
        err          = w_unsupported;
        w_state_nxt  = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_bit   = r_result[0];
        // Result is a shift register: bit 0 is always the one on the wire.
        if (w_tx_fire) begin
          w_result_nxt = r_result >> 1;
          if (r_cnt == CNT_W'(RES_W - 1)) begin
            w_state_nxt = S_RECV_OP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_RECV_OP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RECV_OP;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Fields arrive LSB first, so shifting in at the MSB leaves each field aligned once complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
    end else if (w_rx_fire) begin
      case (r_state)
        S_RECV_OP:  r_op  <= {rx_bit, r_op[OP_WIDTH-1:1]};
        S_RECV_OP1: r_op1 <= {rx_bit, r_op1[REGISTER_SIZE-1:1]};
        S_RECV_OP2: r_op2 <= {rx_bit, r_op2[REGISTER_SIZE-1:1]};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_unit.sv
// Testbench for alu_serial_unit: directed scenarios plus randomized packets against an arithmetic reference.
module tb_alu_serial_unit;
  localparam int RS = 32;
`ifdef ALU_SERIAL_CARRY_OUT_EN
  localparam int TXB = RS + 1;
`else
  localparam int TXB = RS;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0;
  logic rx_bit = 1'b0;
  logic tx_ready = 1'b1;
  logic rx_ready, tx_valid, tx_bit, busy, err;

  int vectors = 0;
  int errors = 0;

  alu_serial_unit #(.REGISTER_SIZE(RS), .OP_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_bit(rx_bit), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_ready(tx_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bit RS holds the ADD carry-out; it is only transmitted when the carry feature is built in.
  function automatic logic [RS:0] model(input int op, input logic [RS-1:0] a, input logic [RS-1:0] b);
    logic [63:0] s;
    s = {32'd0, a} + {32'd0, b};
    case (op)
      0: return s[RS:0];
      1: return {1'b0, a & b};
      2: return {1'b0, a | b};
      default: return '0;
    endcase
  endfunction

  task automatic send_packet(input int op, input logic [RS-1:0] a, input logic [RS-1:0] b,
                             input bit gaps, input bit exp_err);
    logic [2*RS+2:0] pkt;
    logic [2:0] opb;
    opb = op[2:0];
    pkt = {b, a, opb};
    for (int i = 0; i < 3 + 2 * RS; i++) begin
      if (gaps && i > 0) begin
        rx_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL gap_busy bit %0d: busy=%b expected 1", i, busy);
        end
      end
      vectors++;
      if (rx_ready !== 1'b1 || err !== 1'b0 || tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL rx_phase bit %0d: rx_ready=%b err=%b tx_valid=%b expected 1/0/0",
                 i, rx_ready, err, tx_valid);
      end
      vectors++;
      if (busy !== (i != 0)) begin
        errors++;
        $display("FAIL rx_busy bit %0d: busy=%b expected %b", i, busy, (i != 0));
      end
      rx_valid = 1'b1;
      rx_bit   = pkt[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    vectors++;
    if (err !== exp_err || tx_valid !== 1'b0 || rx_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL exec_cycle: err=%b tx_valid=%b rx_ready=%b busy=%b expected %b/0/0/1",
               err, tx_valid, rx_ready, busy, exp_err);
    end
  endtask

  task automatic recv_result(input logic [RS:0] exp, input int stall_bit, input int stall_len,
                             input string name);
    int k;
    int left;
    logic [RS:0] got;
    k = 0;
    left = stall_len;
    got = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < TXB + stall_len + 5; cyc++) begin
      vectors++;
      if (tx_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s tx_valid at bit %0d: got %b expected 1", name, k, tx_valid);
        break;
      end
      vectors++;
      if (tx_bit !== exp[k] || rx_ready !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s bit %0d: tx_bit=%b rx_ready=%b err=%b busy=%b expected %b/0/0/1",
                 name, k, tx_bit, rx_ready, err, busy, exp[k]);
      end
      got[k] = tx_bit;
      if (k == stall_bit && left > 0) begin
        tx_ready = 1'b0;
        left--;
      end else begin
        tx_ready = 1'b1;
        k++;
      end
      if (k == TXB) break;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    vectors++;
    if (k != TXB) begin
      errors++;
      $display("FAIL %s timeout: %0d bits received, expected %0d", name, k, TXB);
    end
    @(negedge clk);
    vectors++;
    if (got[TXB-1:0] !== exp[TXB-1:0]) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, got[TXB-1:0], exp[TXB-1:0]);
    end
    vectors++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0 || tx_bit !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: tx_valid=%b rx_ready=%b busy=%b tx_bit=%b expected 0/1/0/0",
               name, tx_valid, rx_ready, busy, tx_bit);
    end
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_bit !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s: rx_ready=%b tx_valid=%b tx_bit=%b busy=%b err=%b expected 1/0/0/0/0",
               name, rx_ready, tx_valid, tx_bit, busy, err);
    end
  endtask

  task automatic test_reset;
    #12;
    check_reset_values("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_add;
    send_packet(0, 32'd5, 32'd7, 1'b0, 1'b0);
    recv_result(model(0, 32'd5, 32'd7), -1, 0, "add_5_7");
  endtask

  task automatic test_back_to_back;
    send_packet(1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0);
    recv_result(model(1, 32'hF0F0F0F0, 32'hFF00FF00), -1, 0, "and_b2b");
    send_packet(2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0);
    recv_result(model(2, 32'hF0F0F0F0, 32'hFF00FF00), -1, 0, "or_b2b");
  endtask

  task automatic test_add_wrap;
    send_packet(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    recv_result(model(0, 32'hFFFFFFFF, 32'h00000001), -1, 0, "add_wrap");
  endtask

  task automatic test_unsupported;
    send_packet(3, 32'd3, 32'd4, 1'b0, 1'b1);
    recv_result(model(3, 32'd3, 32'd4), -1, 0, "mul_err");
  endtask

  task automatic test_gaps_backpressure;
    send_packet(0, 32'd1, 32'd1, 1'b1, 1'b0);
    recv_result(model(0, 32'd1, 32'd1), 1, 5, "gap_stall");
  endtask

  task automatic test_reset_mid;
    logic [RS-1:0] a;
    a = $urandom;
    for (int i = 0; i < 13; i++) begin
      rx_valid = 1'b1;
      rx_bit   = (i < 3) ? 1'b0 : a[i-3];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_packet(0, 32'd2, 32'd3, 1'b0, 1'b0);
    recv_result(model(0, 32'd2, 32'd3), -1, 0, "add_after_reset");
  endtask

  task automatic test_random;
    int op;
    logic [RS-1:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (n % 4 == 0) b = ~a;
      send_packet(op, a, b, bit'($urandom_range(0, 1)), op > 2);
      recv_result(model(op, a, b), int'($urandom_range(0, TXB - 1)), int'($urandom_range(0, 3)),
                  "random");
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_add_wrap;
    test_unsupported;
    test_gaps_backpressure;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
